// File: rtl/pcs_transmit_ordered_set.sv
// 1000BASE-X PCS transmit: turns GMII octets into 8b/10b code-groups, one per
// clock, inserting /I/, /S/, /T/, /R/ and /V/ ordered sets and keeping the
// even/odd slot alignment and running disparity.
module pcs_transmit_ordered_set #(
    parameter logic [9:0] IDLE_ODD_POS = 10'b1010010110
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] txd,
    input  logic       tx_en,
    input  logic       tx_er,
    output logic [9:0] tx_code_group,
    output logic       tx_even,
    output logic       tx_disparity
);

    // Octet values of the special code-groups (K flag carried separately).
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K30_7 = 8'hFE;
    localparam logic [7:0] D16_2 = 8'h50;

    // Each state names the code-group class currently on the output.
    typedef enum logic [2:0] {
        IDLE_EVEN,
        IDLE_ODD,
        DATA,
        EOP_T,
        EOP_R1,
        EOP_R2
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] code_q, code_d;
    logic       even_q;
    logic       rd_q, rd_d;
    logic       rd_lat_q, rd_lat_d;

    // 5b/6b sub-block, chosen from the RD entering it.
    function automatic logic [5:0] enc6(input logic [4:0] x, input logic rd);
        logic [5:0] b;
        b = 6'b000000;
        case (x)
            5'd0:  b = 6'b100111;  5'd1:  b = 6'b011101;
            5'd2:  b = 6'b101101;  5'd3:  b = 6'b110001;
            5'd4:  b = 6'b110101;  5'd5:  b = 6'b101001;
            5'd6:  b = 6'b011001;  5'd7:  b = 6'b111000;
            5'd8:  b = 6'b111001;  5'd9:  b = 6'b100101;
            5'd10: b = 6'b010101;  5'd11: b = 6'b110100;
            5'd12: b = 6'b001101;  5'd13: b = 6'b101100;
            5'd14: b = 6'b011100;  5'd15: b = 6'b010111;
            5'd16: b = 6'b011011;  5'd17: b = 6'b100011;
            5'd18: b = 6'b010011;  5'd19: b = 6'b110010;
            5'd20: b = 6'b001011;  5'd21: b = 6'b101010;
            5'd22: b = 6'b011010;  5'd23: b = 6'b111010;
            5'd24: b = 6'b110011;  5'd25: b = 6'b100110;
            5'd26: b = 6'b010110;  5'd27: b = 6'b110110;
            5'd28: b = 6'b001110;  5'd29: b = 6'b101110;
            5'd30: b = 6'b011110;  5'd31: b = 6'b101011;
            default: b = 6'b000000;
        endcase
        // RD+ form is the complement for unbalanced blocks; D.7 also alternates.
        if (rd && (($countones(b) != 3) || (x == 5'd7)))
            b = ~b;
        return b;
    endfunction

    // 3b/4b sub-block, chosen from the RD left by the 6b block.
    function automatic logic [3:0] enc4(input logic [2:0] y, input logic [4:0] x,
                                        input logic k, input logic rd);
        logic [3:0] b;
        logic       alt;
        alt = k || (rd ? ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))
                       : ((x == 5'd17) || (x == 5'd18) || (x == 5'd20)));
        case (y)
            3'd0:    b = 4'b1011;
            3'd1:    b = 4'b1001;
            3'd2:    b = 4'b0101;
            3'd3:    b = 4'b1100;
            3'd4:    b = 4'b1101;
            3'd5:    b = k ? 4'b0101 : 4'b1010;
            3'd6:    b = 4'b0110;
            default: b = alt ? 4'b0111 : 4'b1110;
        endcase
        if (rd && (($countones(b) != 2) || (y == 3'd3) || (k && (y == 3'd5))))
            b = ~b;
        return b;
    endfunction

    // Disparity after a sub-block of 2*half bits.
    function automatic logic next_rd(input int ones, input int half, input logic rd);
        if (ones > half)
            return 1'b1;
        else if (ones < half)
            return 1'b0;
        return rd;
    endfunction

    // Full 8b/10b encode: returns {rd_out, abcdei, fghj}.
    function automatic logic [10:0] encode(input logic [7:0] oct, input logic k,
                                           input logic rd);
        logic [5:0] c6;
        logic [3:0] c4;
        logic       r6;
        logic       r4;
        if (k && (oct[4:0] == 5'd28))
            c6 = rd ? 6'b110000 : 6'b001111;
        else
            c6 = enc6(oct[4:0], rd);
        r6 = next_rd($countones(c6), 3, rd);
        c4 = enc4(oct[7:5], oct[4:0], k, r6);
        r4 = next_rd($countones(c4), 2, r6);
        return {r4, c6, c4};
    endfunction

    logic [7:0]  sym;
    logic        sym_k;
    logic        use_raw;
    logic        take_idle;
    logic        slot_even;
    logic [10:0] enc_out;

    // Ordered-set sequencing and code-group selection for the next slot.
    always_comb begin
        state_d   = state_q;
        rd_lat_d  = rd_lat_q;
        sym       = K28_5;
        sym_k     = 1'b1;
        use_raw   = 1'b0;
        take_idle = 1'b0;
        slot_even = ~even_q;
        enc_out   = 11'd0;

        case (state_q)
            IDLE_EVEN: begin
                // Second half of /I/: pick the form that leaves RD negative.
                if (rd_lat_q) begin
                    use_raw = 1'b1;
                end else begin
                    sym_k = 1'b0;
                    sym   = D16_2;
                end
                state_d = IDLE_ODD;
            end
            DATA: begin
                if (!tx_en) begin
                    sym     = K29_7;
                    state_d = EOP_T;
                end else if (tx_er) begin
                    sym = K30_7;
                end else begin
                    sym_k = 1'b0;
                    sym   = txd;
                end
            end
            EOP_T: begin
                sym     = K23_7;
                state_d = EOP_R1;
            end
            EOP_R1: begin
                // A first /R/ in an odd slot already restores alignment.
                if (slot_even) begin
                    take_idle = 1'b1;
                end else begin
                    sym     = K23_7;
                    state_d = EOP_R2;
                end
            end
            default: take_idle = 1'b1;
        endcase

        // Even idle slot: start of frame replaces the octet with /S/.
        if (take_idle) begin
            if (tx_en) begin
                sym     = K27_7;
                state_d = DATA;
            end else begin
                sym      = K28_5;
                rd_lat_d = rd_q;
                state_d  = IDLE_EVEN;
            end
        end

        if (use_raw) begin
            code_d = IDLE_ODD_POS;
            rd_d   = rd_q;
        end else begin
            enc_out = encode(sym, sym_k, rd_q);
            code_d  = enc_out[9:0];
            rd_d    = enc_out[10];
        end
    end

    // Output and state registers; even flag toggles every clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE_ODD;
            code_q   <= 10'd0;
            even_q   <= 1'b0;
            rd_q     <= 1'b0;
            rd_lat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            even_q   <= ~even_q;
            rd_q     <= rd_d;
            rd_lat_q <= rd_lat_d;
        end
    end

    assign tx_code_group = code_q;
    assign tx_even       = even_q;
    assign tx_disparity  = rd_q;

endmodule

// File: tb/tb_pcs_transmit_ordered_set.sv
// Bench for pcs_transmit_ordered_set: directed frames plus random traffic,
// every code-group compared with a symbol-level reference model.
module tb_pcs_transmit_ordered_set;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] txd;
    logic       tx_en;
    logic       tx_er;
    logic [9:0] tx_code_group;
    logic       tx_even;
    logic       tx_disparity;

    pcs_transmit_ordered_set dut (
        .clk           (clk),
        .reset         (reset),
        .txd           (txd),
        .tx_en         (tx_en),
        .tx_er         (tx_er),
        .tx_code_group (tx_code_group),
        .tx_even       (tx_even),
        .tx_disparity  (tx_disparity)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K30_7 = 8'hFE;

    // Both disparity columns written out in full.
    localparam logic [5:0] T6M [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [5:0] T6P [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    localparam logic [3:0] T4M [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                                       4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] T4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                       4'b0010, 4'b1010, 4'b0110, 4'b0001};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: slot parity of next code, in-frame, /R/ owed, RD.
    logic m_even;
    logic m_frame;
    int   m_rs;
    logic m_rd;

    logic [9:0] last_code;
    logic       last_even;
    logic       last_rd;
    logic       en_r;

    task automatic model_reset();
        m_even  = 1'b1;
        m_frame = 1'b0;
        m_rs    = 0;
        m_rd    = 1'b0;
    endtask

    task automatic model_enc(input logic [7:0] oct, input logic k, input logic rdi,
                             output logic [9:0] code, output logic rdo);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] c6;
        logic [3:0] c4;
        logic       r6;
        logic       alt;
        x = oct[4:0];
        y = oct[7:5];
        if (k && x == 5'd28) c6 = rdi ? 6'b110000 : 6'b001111;
        else                 c6 = rdi ? T6P[x] : T6M[x];
        r6 = ($countones(c6) > 3) ? 1'b1 : (($countones(c6) < 3) ? 1'b0 : rdi);
        if (y == 3'd7) begin
            alt = k || (r6 ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                           : (x == 5'd17 || x == 5'd18 || x == 5'd20));
            if (alt) c4 = r6 ? 4'b1000 : 4'b0111;
            else     c4 = r6 ? 4'b0001 : 4'b1110;
        end else if (k && y == 3'd5) begin
            c4 = r6 ? 4'b1010 : 4'b0101;
        end else begin
            c4 = r6 ? T4P[y] : T4M[y];
        end
        rdo  = ($countones(c4) > 2) ? 1'b1 : (($countones(c4) < 2) ? 1'b0 : r6);
        code = {c6, c4};
    endtask

    task automatic model_step(input logic en, input logic er, input logic [7:0] d,
                              output logic [9:0] code, output logic ev, output logic rdo);
        logic [7:0] sym;
        logic       k;
        logic       slot;
        logic       nrd;
        slot = m_even;
        k    = 1'b1;
        sym  = K28_5;
        if (m_rs > 0) begin
            sym  = K23_7;
            m_rs = m_rs - 1;
        end else if (m_frame) begin
            if (!en) begin
                sym     = K29_7;
                m_frame = 1'b0;
                m_rs    = slot ? 1 : 2;
            end else if (er) begin
                sym = K30_7;
            end else begin
                k   = 1'b0;
                sym = d;
            end
        end else if (slot) begin
            if (en) begin
                sym     = K27_7;
                m_frame = 1'b1;
            end
        end else begin
            k   = 1'b0;
            sym = m_rd ? 8'h50 : 8'hC5;
        end
        model_enc(sym, k, m_rd, code, nrd);
        m_rd   = nrd;
        m_even = ~m_even;
        ev     = slot;
        rdo    = m_rd;
    endtask

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic er, input logic [7:0] d);
        logic [9:0] ec;
        logic       ee;
        logic       erd;
        tx_en = en;
        tx_er = er;
        txd   = d;
        model_step(en, er, d, ec, ee, erd);
        @(posedge clk);
        #1;
        last_code = tx_code_group;
        last_even = tx_even;
        last_rd   = tx_disparity;
        chk("code", last_code, ec);
        chk("even", {9'd0, last_even}, {9'd0, ee});
        chk("rd", {9'd0, last_rd}, {9'd0, erd});
    endtask

    task automatic reset_pulse();
        #1;
        reset = 1'b0;
        #1;
        chk("rst_code", tx_code_group, 10'd0);
        chk("rst_even", {9'd0, tx_even}, 10'd0);
        chk("rst_rd", {9'd0, tx_disparity}, 10'd0);
        #24;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        reset = 1'b0;
        tx_en = 1'b0;
        tx_er = 1'b0;
        txd   = 8'h00;
        en_r  = 1'b0;
        model_reset();
        #12;
        chk("init_code", tx_code_group, 10'd0);
        chk("init_even", {9'd0, tx_even}, 10'd0);
        chk("init_rd", {9'd0, tx_disparity}, 10'd0);
        reset = 1'b1;

        // Idle after reset release
        step(0, 0, 8'h00);
        chk("idle_k285", last_code, 10'b0011111010);
        chk("idle_k285_even", {9'd0, last_even}, 10'd1);
        step(0, 0, 8'h00);
        chk("idle_d162", last_code, 10'b1001000101);
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);

        // Two-octet frame starting in an even slot
        step(1, 0, 8'h55);
        chk("f2_s", last_code, 10'b1101101000);
        step(1, 0, 8'h04);
        chk("f2_d40", last_code, 10'b1101010100);
        step(0, 0, 8'h00);
        chk("f2_t", last_code, 10'b1011101000);
        step(0, 0, 8'h00);
        chk("f2_r", last_code, 10'b1110101000);
        step(0, 0, 8'h00);
        chk("f2_idle", last_code, 10'b0011111010);
        step(0, 1, 8'h00);

        // Three-octet frame: /T/ odd needs two /R/
        step(1, 0, 8'h55);
        step(1, 0, 8'h04);
        step(1, 0, 8'h04);
        step(0, 0, 8'h00);
        chk("f3_t_odd", {9'd0, last_even}, 10'd0);
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        chk("f3_r2", last_code, 10'b1110101000);
        step(0, 0, 8'h00);
        chk("f3_idle", last_code, 10'b0011111010);
        chk("f3_idle_even", {9'd0, last_even}, 10'd1);
        step(0, 0, 8'h00);

        // tx_en rising in an odd slot, then /V/ mid-frame
        step(0, 0, 8'h00);
        step(1, 0, 8'h55);
        chk("odd_rise_i2", last_code, 10'b1001000101);
        step(1, 0, 8'h55);
        chk("odd_rise_s", last_code, 10'b1101101000);
        step(1, 0, 8'h01);
        chk("odd_rise_d10", last_code, 10'b0111010100);
        step(1, 1, 8'h33);
        chk("v_rdneg", last_code, 10'b0111101000);
        step(1, 0, 8'h04);
        chk("after_v", last_code, 10'b1101010100);
        step(1, 0, 8'hF1);
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);

        // Reset in the middle of a frame
        step(1, 0, 8'hAA);
        step(1, 0, 8'h12);
        reset_pulse();
        step(0, 0, 8'h00);
        chk("rec_k285", last_code, 10'b0011111010);
        chk("rec_even", {9'd0, last_even}, 10'd1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) en_r = ~en_r;
            step(en_r, ($urandom_range(0, 15) == 0), 8'($urandom));
            if (i == 300) begin
                reset_pulse();
                en_r = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
